// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one FRAME_W-bit full-duplex frame per accepted start, MSB first.
// Busy for CS_SETUP + 2*CLK_DIV*FRAME_W + CS_HOLD + CS_GAP cycles; start is ignored while busy.
module spi_master_ctrl #(
    parameter int FRAME_W  = 20,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] tx_data,
    output logic               busy,
    output logic               done,
    output logic [FRAME_W-1:0] rx_data,
    output logic               sclk,
    output logic               ss_n,
    output logic               mosi,
    input  logic               miso
);

    localparam int CNT_W = $clog2(CLK_DIV + CS_SETUP + CS_HOLD + CS_GAP + 1);
    localparam int BIT_W = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BITS       = BIT_W'(FRAME_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    // MSB of the frame goes straight to mosi, so only the remaining bits are queued here.
    logic [FRAME_W-2:0] tx_sr_q, tx_sr_d;
    logic [FRAME_W-1:0] rx_sr_q, rx_sr_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               sclk_q, sclk_d;
    logic               ss_n_q, ss_n_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            ss_n_q    <= ss_n_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        ss_n_d    = ss_n_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    tx_sr_d   = tx_data[FRAME_W-2:0];
                    mosi_d    = tx_data[FRAME_W-1];
                    ss_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d    = 1'b1;
                        rx_sr_d   = (rx_sr_q << 1) | FRAME_W'(miso);
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q < BITS) begin
                            mosi_d  = tx_sr_q[FRAME_W-2];
                            tx_sr_d = tx_sr_q << 1;
                        end else begin
                            mosi_d  = 1'b0;
                            state_d = S_HOLD;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    ss_n_d  = 1'b1;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d     = '0;
                    rx_data_d = rx_sr_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign ss_n    = ss_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboarded bench for spi_master_ctrl: default 20-bit instance plus an 8-bit, CLK_DIV=1 instance.
module tb_spi_master_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    always #5 clk = ~clk;

    // default instance
    logic        start;
    logic [19:0] tx_data;
    logic        busy, done, sclk, ss_n, mosi, miso;
    logic [19:0] rx_data;

    // 8-bit, CLK_DIV=1 instance in loopback
    logic        start2;
    logic [7:0]  tx2;
    logic        busy2, done2, sclk2, ss_n2, mosi2, miso2;
    logic [7:0]  rx2;

    spi_master_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk),
        .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );

    spi_master_ctrl #(.FRAME_W(8), .CLK_DIV(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .tx_data(tx2),
        .busy(busy2), .done(done2), .rx_data(rx2), .sclk(sclk2),
        .ss_n(ss_n2), .mosi(mosi2), .miso(miso2)
    );
    assign miso2 = mosi2;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // slave side: 0 = loopback, 1 = miso tied high, 2 = shift out slave_word MSB first
    int          miso_mode = 0;
    logic [19:0] slave_word = '0;
    logic [19:0] sl_sr = '0;
    logic        prev_ss_s = 1'b1, prev_sclk_s = 1'b0;

    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? 1'b1 : sl_sr[19];

    always @(negedge clk) begin
        if (prev_ss_s && !ss_n)       sl_sr = slave_word;
        else if (prev_sclk_s && !sclk) sl_sr = sl_sr << 1;
        prev_ss_s   = ss_n;
        prev_sclk_s = sclk;
    end

    typedef struct {
        logic [19:0] tx;
        logic [19:0] rx;
        bit          b2b;
    } exp_t;
    exp_t q[$];
    logic [7:0] q2[$];

    // monitor for the default instance
    int          rise_cnt = 0, busy_cnt = 0, ss_cyc = 0, ss_hi_run = 0;
    logic [19:0] mosi_word = '0;
    logic        mosi_hi = 1'b0, prev_sclk = 1'b0, prev_ss = 1'b1, prev_done = 1'b0;
    exp_t        e;

    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            rise_cnt = 0; busy_cnt = 0; ss_cyc = 0; ss_hi_run = 0;
            mosi_word = '0; mosi_hi = 1'b0;
            prev_sclk = 1'b0; prev_ss = 1'b1; prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (prev_ss && !ss_n) begin
                ss_cyc = 0;
                if (q.size() > 0 && q[0].b2b) check("ss_n_high_between_frames", ss_hi_run, 3);
            end else begin
                ss_cyc++;
            end
            ss_hi_run = ss_n ? ss_hi_run + 1 : 0;
            if (mosi) mosi_hi = 1'b1;
            if (sclk && !prev_sclk) begin
                rise_cnt++;
                mosi_word = {mosi_word[18:0], mosi};
                if (rise_cnt == 1) check("first_rise_delay", ss_cyc, 4);
            end
            if (done) begin
                check("done_single_pulse", 32'(prev_done), 0);
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.rx));
                    check("mosi_at_rises", 32'(mosi_word), 32'(e.tx));
                    check("rise_count", rise_cnt, 20);
                    check("busy_cycles", busy_cnt, 86);
                    check("mosi_ever_high", 32'(mosi_hi), 32'(e.tx != 20'h0));
                end
                rise_cnt = 0; busy_cnt = 0; mosi_word = '0; mosi_hi = 1'b0;
            end
            prev_sclk = sclk;
            prev_ss   = ss_n;
            prev_done = done;
        end
    end

    // monitor for the 8-bit instance
    int   b2 = 0, r2 = 0, t2 = 0, cyc2 = 0, first_t2 = 0, last_t2 = 0;
    logic p_sclk2 = 1'b0;
    logic [7:0] e2;

    always @(negedge clk) begin
        if (!reset_n) begin
            q2.delete();
            b2 = 0; r2 = 0; t2 = 0; cyc2 = 0; p_sclk2 = 1'b0;
        end else begin
            if (busy2) begin
                b2++;
                cyc2++;
            end
            if (sclk2 != p_sclk2) begin
                if (t2 == 0) first_t2 = cyc2;
                last_t2 = cyc2;
                t2++;
            end
            if (sclk2 && !p_sclk2) r2++;
            if (done2) begin
                if (q2.size() == 0) begin
                    check("unexpected_done2", 1, 0);
                end else begin
                    e2 = q2.pop_front();
                    check("rx_data2", 32'(rx2), 32'(e2));
                    check("busy_cycles2", b2, 22);
                    check("rise_count2", r2, 8);
                    check("sclk_toggles2", t2, 16);
                    check("sclk_toggle_span2", last_t2 - first_t2, 15);
                end
                b2 = 0; r2 = 0; t2 = 0; cyc2 = 0;
            end
            p_sclk2 = sclk2;
        end
    end

    task automatic wait_idle();
        int k;
        for (k = 0; k < 300 && busy; k++) begin
            @(posedge clk);
            #1;
        end
        if (busy) check("timeout_idle", 0, 1);
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (!done) check("timeout_done", 0, 1);
    endtask

    task automatic push_exp(input logic [19:0] tx, input int mode, input logic [19:0] sw,
                            input bit b2b);
        exp_t x;
        x.tx  = tx;
        x.rx  = (mode == 0) ? tx : (mode == 1) ? 20'hFFFFF : sw;
        x.b2b = b2b;
        q.push_back(x);
    endtask

    task automatic send(input logic [19:0] tx, input int mode, input logic [19:0] sw);
        wait_idle();
        tx_data    = tx;
        miso_mode  = mode;
        slave_word = sw;
        push_exp(tx, mode, sw, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tx_data = ~tx;
    endtask

    task automatic send2(input logic [7:0] v);
        int k;
        tx2 = v;
        q2.push_back(v);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (done2) break;
        end
        if (!done2) check("timeout_done2", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset_n = 1'b0;
        start   = 1'b0;
        tx_data = '0;
        start2  = 1'b0;
        tx2     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({sclk, ss_n, mosi, busy, done}), 32'(5'b01000));
        check("reset_rx_data", 32'(rx_data), 0);
        reset_n = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check("idle_outputs", 32'({sclk, ss_n, mosi, busy, done, rx_data}), 32'({5'b01000, 20'h0}));
        end

        // loopback, miso tied high with all-zero tx, then fixed slave response
        send(20'hA5C3F, 0, 20'h0);
        wait_done();
        send(20'h00000, 1, 20'h0);
        wait_done();
        send(20'h55555, 2, 20'h30F0A);
        wait_done();

        // start held high for a whole frame and through done: second frame follows back to back
        wait_idle();
        tx_data    = 20'h55555;
        miso_mode  = 2;
        slave_word = 20'h30F0A;
        push_exp(20'h55555, 2, 20'h30F0A, 1'b0);
        push_exp(20'h55555, 2, 20'h30F0A, 1'b1);
        start = 1'b1;
        wait_done();
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_accepted", 32'(busy), 1);
        wait_done();

        // abort mid-frame after 10 rising edges
        send(20'hC3A96, 2, 20'h6B2D1);
        for (k = 0; k < 200 && rise_cnt < 10; k++) begin
            @(posedge clk);
            #1;
        end
        check("reached_10_rises", 32'(rise_cnt >= 10), 1);
        reset_n = 1'b0;
        #1;
        check("abort_outputs", 32'({sclk, ss_n, mosi, busy, done}), 32'(5'b01000));
        check("abort_rx_data", 32'(rx_data), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        send(20'h1E2D3, 2, 20'h9ABCD);
        wait_done();

        for (int i = 0; i < 6; i++) begin
            send(20'($urandom), int'($urandom_range(0, 2)), 20'($urandom));
            wait_done();
        end

        send2(8'h81);
        for (int i = 0; i < 3; i++) send2(8'($urandom));

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        check("queue2_drained", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
